// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLLRST = 2'd0,
    WAIT   = 2'd1,
    STABLE = 2'd2,
    RUN    = 2'd3
  } pll_seq_state_t;

  localparam int unsigned PLL_SEQ_RST_PULSE    = 16;
  localparam int unsigned PLL_SEQ_LOCK_STABLE  = 4096;
  localparam int unsigned PLL_SEQ_LOCK_TIMEOUT = 1000000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level; latency 2 cycles.
module sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for stable lock, retries on timeout.
// Optional loss-of-lock counter and port enabled by macro PLL_SEQ_LOSS_CNT_EN.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE    = PLL_SEQ_RST_PULSE,
  parameter int unsigned LOCK_STABLE  = PLL_SEQ_LOCK_STABLE,
  parameter int unsigned LOCK_TIMEOUT = PLL_SEQ_LOCK_TIMEOUT,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [CNT_W-1:0] loss_cnt
`endif
);

  localparam int unsigned CW = $clog2(max3(RST_PULSE, LOCK_STABLE, LOCK_TIMEOUT) + 1);

  pll_seq_state_t  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic            retry_inc;
  logic            pll_rst_q, sys_rst_q, ready_q;
  logic            lk;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_q, loss_d;
  logic            loss_inc;
`endif

  sync_bit u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (locked),
    .q_o (lk)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    retry_inc = 1'b0;
`ifdef PLL_SEQ_LOSS_CNT_EN
    loss_inc  = 1'b0;
`endif
    case (state_q)
      PLLRST: begin
        if (cnt_q == CW'(RST_PULSE - 1)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // Lock arriving on the timeout cycle takes priority over a retry.
        if (lk) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d   = PLLRST;
          cnt_d     = '0;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lk) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!lk) begin
          state_d  = PLLRST;
          cnt_d    = '0;
`ifdef PLL_SEQ_LOSS_CNT_EN
          loss_inc = 1'b1;
`endif
        end
      end
      default: begin
        state_d = PLLRST;
        cnt_d   = '0;
      end
    endcase
  end

  assign retry_d = (retry_inc && (retry_q != '1)) ? retry_q + CNT_W'(1) : retry_q;
`ifdef PLL_SEQ_LOSS_CNT_EN
  assign loss_d  = (loss_inc && (loss_q != '1)) ? loss_q + CNT_W'(1) : loss_q;
`endif

  // Outputs decode the next state so all three move together on one edge.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= PLLRST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
`ifdef PLL_SEQ_LOSS_CNT_EN
      loss_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == PLLRST);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
`ifdef PLL_SEQ_LOSS_CNT_EN
      loss_q    <= loss_d;
`endif
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign retry_cnt = retry_q;
`ifdef PLL_SEQ_LOSS_CNT_EN
  assign loss_cnt  = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: expected output transitions are queued by stimulus, popped by a monitor.
module tb_pll_reset_seq;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int TO = 32;
  localparam int CW = 8;
`ifdef PLL_SEQ_LOSS_CNT_EN
  localparam bit HAS_LOSS = 1'b1;
`else
  localparam bit HAS_LOSS = 1'b0;
`endif

  logic          refclk = 1'b0;
  logic          rst    = 1'b1;
  logic          locked = 1'b0;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic [CW-1:0] retry_cnt;
  logic [CW-1:0] loss_w;

  pll_reset_seq #(
    .RST_PULSE    (RP),
    .LOCK_STABLE  (LS),
    .LOCK_TIMEOUT (TO),
    .CNT_W        (CW)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .retry_cnt (retry_cnt)
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_w)
`endif
  );
`ifndef PLL_SEQ_LOSS_CNT_EN
  assign loss_w = '0;
`endif

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int            c;
    logic [2:0]    o;
    logic [CW-1:0] r;
    logic [CW-1:0] l;
  } ev_t;
  ev_t q[$];

  task automatic push(input int c, input logic p, input logic s, input logic y,
                      input int r, input int l);
    ev_t e;
    e.c = c;
    e.o = {p, s, y};
    e.r = CW'(r);
    e.l = HAS_LOSS ? CW'(l) : '0;
    q.push_back(e);
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", n, a, e);
    end
  endtask

  // Monitor: every change of {pll_rst,sys_rst,ready} must match the next queued event.
  logic [2:0] prev;
  bit         mon_en = 1'b0;
  always @(negedge refclk) begin
    logic [2:0] cur;
    ev_t        e;
    cur = {pll_rst, sys_rst, ready};
    if (mon_en && (cur !== prev)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_transition cyc=%0d got={pll,sys,rdy}=%b retry=%0d loss=%0d",
                 cyc, cur, retry_cnt, loss_w);
      end else begin
        e = q.pop_front();
        if ((e.c != cyc) || (e.o !== cur) || (e.r !== retry_cnt) || (e.l !== loss_w)) begin
          fails++;
          $display("FAIL transition got cyc=%0d out=%b retry=%0d loss=%0d exp cyc=%0d out=%b retry=%0d loss=%0d",
                   cyc, cur, retry_cnt, loss_w, e.c, e.o, e.r, e.l);
        end
      end
    end
    prev = cur;
  end

  initial begin
    int c0, r0, t, s0, r2, c1, rv;

    // Reset state
    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_sys_rst", sys_rst, 1);
    chk("reset_ready", ready, 0);
    chk("reset_retry_cnt", retry_cnt, 0);
    chk("reset_loss_cnt", loss_w, 0);
    mon_en = 1'b1;

    // 1: release, lock arrives as the PLL comes out of reset
    rst = 1'b0;
    c0  = cyc;
    push(c0 + 4, 0, 1, 0, 0, 0);
    tick_to(c0 + 4);
    locked = 1'b1;
    r0 = c0 + 15;
    push(r0, 0, 0, 1, 0, 0);

    // 4: lock loss in RUN, then 2: held unlocked for three timeouts
    tick_to(r0 + 2);
    locked = 1'b0;
    push(r0 + 5, 1, 1, 0, 0, 1);
    t = r0 + 9;
    push(t, 0, 1, 0, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      t += TO;
      push(t, 1, 1, 0, k, 1);
      t += RP;
      push(t, 0, 1, 0, k, 1);
    end

    // 3: one-cycle lock dropout at stable count 5
    tick_to(t);
    locked = 1'b1;
    s0 = t + 3;
    tick_to(s0 + 3);
    locked = 1'b0;
    tick_to(s0 + 4);
    locked = 1'b1;
    r2 = s0 + 15;
    push(r2, 0, 0, 1, 3, 1);

    // 5: second loss, then timeouts up to 300 total
    tick_to(r2);
    locked = 1'b0;
    push(r2 + 3, 1, 1, 0, 3, 2);
    t = r2 + 7;
    push(t, 0, 1, 0, 3, 2);
    for (int k = 4; k <= 300; k++) begin
      rv = (k > 255) ? 255 : k;
      t += TO;
      push(t, 1, 1, 0, rv, 2);
      t += RP;
      push(t, 0, 1, 0, rv, 2);
    end
    tick_to(t);
    chk("retry_saturated", retry_cnt, 255);

    // 6: reach RUN, then reset while running
    locked = 1'b1;
    push(t + 11, 0, 0, 1, 255, 2);
    tick_to(t + 13);
    rst = 1'b1;
    push(t + 14, 1, 1, 0, 0, 0);
    tick_to(t + 14);
    chk("run_reset_retry_cnt", retry_cnt, 0);
    chk("run_reset_loss_cnt", loss_w, 0);
    tick_to(t + 16);
    rst = 1'b0;
    c1 = cyc;
    push(c1 + 4, 0, 1, 0, 0, 0);
    push(c1 + 13, 0, 0, 1, 0, 0);
    tick_to(c1 + 20);

    chk("events_consumed", q.size(), 0);
    chk("final_ready", ready, 1);
    chk("final_retry_cnt", retry_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
